corr_peak_trigger: RTL and testbench

//  Consumer of the per-clock 12-bit CORR outputs from a bank of NCORR correlators (one per delay hypothesis).

---
 rtl/corr_peak_trigger.sv | 91 +++++++++
 tb/tb_corr_peak_trigger.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/corr_peak_trigger.sv
// corr_peak_trigger: pipelined max-of-NCORR peak finder with threshold trigger, ack handshake and holdoff
module corr_peak_trigger #(
    parameter int NCORR   = 8,
    parameter int CBITS   = 12,
    parameter int IDXBITS = 3,
    parameter int HOLDOFF = 16,
    parameter int HBITS   = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NCORR*CBITS-1:0] CORR,
    input  logic [CBITS-1:0]       THRESHOLD,
    input  logic                   THR_WR,
    input  logic                   TRIG_ACK,
    output logic                   TRIG,
    output logic [CBITS-1:0]       TRIG_VALUE,
    output logic [IDXBITS-1:0]     TRIG_IDX,
    output logic                   BUSY,
    output logic [7:0]             MISSED
);
    localparam int NN = 2*NCORR-1;
    typedef enum logic [1:0] {S_IDLE, S_TRIG, S_HOLD} state_t;
    logic [CBITS-1:0]   v [NN];
    logic [IDXBITS-1:0] x [NN];
    logic [CBITS-1:0]   thr, pv;
    logic [IDXBITS-1:0] pi;
    logic               flag;
    logic [HBITS-1:0]   cnt, ncnt;
    state_t             state, nstate;
    genvar i;
    for (i = 0; i < NCORR; i++) begin : g_leaf
        always_ff @(posedge clk) begin
            if (rst) begin
                v[NCORR-1+i] <= '0;
                x[NCORR-1+i] <= '0;
            end else begin
                v[NCORR-1+i] <= CORR[i*CBITS +: CBITS];
                x[NCORR-1+i] <= IDXBITS'(i);
            end
        end
    end
    for (i = 0; i < NCORR-1; i++) begin : g_node
        always_ff @(posedge clk) begin
            if (rst) begin
                v[i] <= '0;
                x[i] <= '0;
            end else begin
                v[i] <= (v[2*i+2] > v[2*i+1]) ? v[2*i+2] : v[2*i+1];
                x[i] <= (v[2*i+2] > v[2*i+1]) ? x[2*i+2] : x[2*i+1];
            end
        end
    end
    always_comb begin
        nstate = state;
        ncnt   = cnt;
        if (state == S_IDLE && flag) nstate = S_TRIG;
        if (state == S_TRIG && TRIG_ACK) begin
            nstate = (HOLDOFF == 0) ? S_IDLE : S_HOLD;
            ncnt   = HBITS'(HOLDOFF);
        end
        if (state == S_HOLD) begin
            nstate = (cnt == HBITS'(1)) ? S_IDLE : S_HOLD;
            ncnt   = cnt - 1'b1;
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            thr        <= '1;
            flag       <= 1'b0;
            pv         <= '0;
            pi         <= '0;
            state      <= S_IDLE;
            cnt        <= '0;
            TRIG_VALUE <= '0;
            TRIG_IDX   <= '0;
            MISSED     <= '0;
        end else begin
            thr        <= THR_WR ? THRESHOLD : thr;
            flag       <= v[0] > thr;
            pv         <= v[0];
            pi         <= x[0];
            state      <= nstate;
            cnt        <= ncnt;
            TRIG_VALUE <= (state == S_IDLE && flag) ? pv : TRIG_VALUE;
            TRIG_IDX   <= (state == S_IDLE && flag) ? pi : TRIG_IDX;
            MISSED     <= (flag && state != S_IDLE && MISSED != 8'hff) ? MISSED + 8'd1 : MISSED;
        end
    end
    assign TRIG = (state == S_TRIG);
    assign BUSY = (state != S_IDLE);
endmodule

// File: tb/tb_corr_peak_trigger.sv
// tb_corr_peak_trigger: directed scoreboard bench for corr_peak_trigger
module tb_corr_peak_trigger;
    localparam int N  = 8;
    localparam int CB = 12;
    localparam int IB = 3;
    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [N*CB-1:0]   CORR = '0;
    logic [CB-1:0]     THRESHOLD = '0;
    logic              THR_WR = 1'b0;
    logic              TRIG_ACK = 1'b0;
    logic              TRIG;
    logic [CB-1:0]     TRIG_VALUE;
    logic [IB-1:0]     TRIG_IDX;
    logic              BUSY;
    logic [7:0]        MISSED;
    int                checks = 0;
    int                errors = 0;
    int                cyc = 0;
    int                c0;
    logic [CB+IB-1:0]  sb[$];

    always #5 clk = ~clk;

    corr_peak_trigger #(.NCORR(N), .CBITS(CB), .IDXBITS(IB), .HOLDOFF(16), .HBITS(8)) dut (
        .clk(clk), .rst(rst), .CORR(CORR), .THRESHOLD(THRESHOLD), .THR_WR(THR_WR),
        .TRIG_ACK(TRIG_ACK), .TRIG(TRIG), .TRIG_VALUE(TRIG_VALUE), .TRIG_IDX(TRIG_IDX),
        .BUSY(BUSY), .MISSED(MISSED)
    );

    task automatic tick;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic set_all(input logic [CB-1:0] val);
        for (int k = 0; k < N; k++) CORR[k*CB +: CB] = val;
    endtask

    task automatic write_thr(input logic [CB-1:0] val);
        THRESHOLD = val;
        THR_WR = 1'b1;
        tick;
        THR_WR = 1'b0;
    endtask

    task automatic do_ack;
        TRIG_ACK = 1'b1;
        tick;
        TRIG_ACK = 1'b0;
    endtask

    task automatic expect_trig(input string tag, input int lat);
        int n;
        logic [CB+IB-1:0] e;
        n = 0;
        while (TRIG !== 1'b1 && n < lat + 20) begin
            tick;
            n++;
        end
        chk({tag, "_latency"}, n, lat);
        chk({tag, "_sb_nonempty"}, sb.size() > 0, 1);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk({tag, "_value"}, TRIG_VALUE, e[CB+IB-1:IB]);
            chk({tag, "_idx"}, TRIG_IDX, e[IB-1:0]);
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_trig"}, TRIG, 0);
        chk({tag, "_value"}, TRIG_VALUE, 0);
        chk({tag, "_idx"}, TRIG_IDX, 0);
        chk({tag, "_busy"}, BUSY, 0);
        chk({tag, "_missed"}, MISSED, 0);
    endtask

    initial begin
        rst = 1'b1;
        tick;
        tick;
        chk_reset("rst0");
        rst = 1'b0;
        // single-cycle crossing at index 5
        set_all(12'd50);
        write_thr(12'd100);
        CORR[5*CB +: CB] = 12'd101;
        sb.push_back({12'd101, 3'd5});
        tick;
        set_all(12'd50);
        expect_trig("t1", 5);
        do_ack;
        chk("t1_ack_trig", TRIG, 0);
        chk("t1_ack_busy", BUSY, 1);
        repeat (15) tick;
        chk("t1_hold_last_busy", BUSY, 1);
        tick;
        chk("t1_idle", BUSY, 0);
        chk("t1_missed", MISSED, 0);
        // tie between idx2 and idx6
        set_all(12'd0);
        CORR[2*CB +: CB] = 12'd300;
        CORR[6*CB +: CB] = 12'd300;
        sb.push_back({12'd300, 3'd2});
        tick;
        set_all(12'd0);
        expect_trig("t2", 5);
        do_ack;
        repeat (16) tick;
        chk("t2_idle", BUSY, 0);
        // 40-cycle sustained crossing, ack 3 cycles after TRIG
        CORR[7*CB +: CB] = 12'd200;
        sb.push_back({12'd200, 3'd7});
        sb.push_back({12'd200, 3'd7});
        tick;
        c0 = cyc;
        expect_trig("t3a", 5);
        tick;
        tick;
        do_ack;
        chk("t3_ack_trig", TRIG, 0);
        chk("t3_ack_busy", BUSY, 1);
        chk("t3_ack_missed", MISSED, 3);
        expect_trig("t3b", 17);
        while (cyc < c0 + 39) tick;
        set_all(12'd0);
        repeat (8) tick;
        chk("t3_missed", MISSED, 38);
        chk("t3_trig_held", TRIG, 1);
        do_ack;
        repeat (16) tick;
        chk("t3_idle", BUSY, 0);
        // strict compare, then lower threshold
        set_all(12'd100);
        repeat (10) tick;
        chk("t4_strict_trig", TRIG, 0);
        chk("t4_strict_missed", MISSED, 38);
        sb.push_back({12'd100, 3'd0});
        write_thr(12'd99);
        expect_trig("t4", 2);
        set_all(12'd0);
        repeat (8) tick;
        chk("t4_missed", MISSED, 43);
        do_ack;
        repeat (16) tick;
        chk("t4_idle", BUSY, 0);
        // reset while triggered
        rst = 1'b1;
        tick;
        rst = 1'b0;
        chk_reset("rst1");
        set_all(12'd0);
        write_thr(12'd100);
        CORR[3*CB +: CB] = 12'd500;
        sb.push_back({12'd500, 3'd3});
        tick;
        expect_trig("t5", 5);
        repeat (7) tick;
        chk("t5_missed7", MISSED, 7);
        chk("t5_trig_pre", TRIG, 1);
        rst = 1'b1;
        tick;
        rst = 1'b0;
        chk("t5_rst_trig", TRIG, 0);
        chk("t5_rst_busy", BUSY, 0);
        chk("t5_rst_missed", MISSED, 0);
        set_all(12'hfff);
        repeat (20) tick;
        chk("t5_no_trig", TRIG, 0);
        chk("t5_no_busy", BUSY, 0);
        chk("t5_no_missed", MISSED, 0);
        // MISSED saturation
        set_all(12'd0);
        repeat (6) tick;
        write_thr(12'd100);
        CORR[1*CB +: CB] = 12'd1000;
        sb.push_back({12'd1000, 3'd1});
        tick;
        expect_trig("t6", 5);
        repeat (100) tick;
        chk("t6_missed100", MISSED, 100);
        repeat (200) tick;
        chk("t6_saturated", MISSED, 255);
        chk("t6_trig_held", TRIG, 1);
        chk("sb_empty", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
